// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and widths for the SDRAM port arbiter
package sdram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int NUM_W  = 10;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    XFER  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } arb_state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  // A beat count of zero still moves one word through the controller.
  function automatic logic [NUM_W-1:0] fix_num(input logic [NUM_W-1:0] num);
    return (num == '0) ? NUM_W'(1) : num;
  endfunction

endpackage

// File: rtl/sdram_arb_select.sv
// rtl/sdram_arb_select.sv - winner pick for the SDRAM arbiter (SDRAM_ARB_ROUND_ROBIN_EN selects round robin)
module sdram_arb_select
  import sdram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_grant,
`ifndef SDRAM_ARB_ROUND_ROBIN_EN
  input  logic     starve,
`endif
  output port_id_t winner
);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // On a tie the port that did not win last time goes next.
  always_comb begin
    winner = PORT0;
    if (req0 && req1) begin
      winner = (last_grant == PORT1) ? PORT0 : PORT1;
    end else if (req1) begin
      winner = PORT1;
    end
  end
`else
  // Video fetch wins ties unless the CPU side has waited too long.
  always_comb begin
    winner = PORT0;
    if (req0 && starve) begin
      winner = PORT0;
    end else if (req1) begin
      winner = PORT1;
    end
  end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port KFSDRAM request arbiter (SDRAM_ARB_ROUND_ROBIN_EN selects round robin)
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              sdram_clock,
  input  logic              sdram_reset_n,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [NUM_W-1:0]  p0_num,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_write,
  input  logic              p0_read,
  output logic              p0_grant,
  output logic              p0_wready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [NUM_W-1:0]  p1_num,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_write,
  input  logic              p1_read,
  output logic              p1_grant,
  output logic              p1_wready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic [ADDR_W-1:0] ctl_address,
  output logic [NUM_W-1:0]  ctl_num,
  output logic [DATA_W-1:0] ctl_data_in,
  output logic              ctl_write_request,
  output logic              ctl_read_request,
  input  logic              ctl_write_flag,
  input  logic              ctl_read_flag,
  input  logic [DATA_W-1:0] ctl_data_out,
  input  logic              ctl_idle,
  input  logic              ctl_refresh_mode
);

  arb_state_t state, state_next;
  port_id_t   owner;
  port_id_t   last_grant;
  port_id_t   winner;
  logic       op_write;
  logic       req0, req1;
  logic       owner_req;
  logic       flag;
  logic       start;
  logic       done_q;
  logic       rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [NUM_W-1:0]  beat_cnt;

  assign req0      = p0_read | p0_write;
  assign req1      = p1_read | p1_write;
  assign owner_req = (owner == PORT1) ? req1 : req0;
  assign flag      = ctl_write_flag | ctl_read_flag;
  // Refresh is never interrupted: a decision needs an idle, non-refreshing controller.
  assign start     = (state == IDLE) && ctl_idle && !ctl_refresh_mode && (req0 || req1);

`ifndef SDRAM_ARB_ROUND_ROBIN_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve;

  assign starve = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

  // Count CPU-side waiting cycles, saturating at the limit; cleared when port 0 wins.
  always_ff @(posedge sdram_clock or negedge sdram_reset_n) begin
    if (!sdram_reset_n) begin
      starve_cnt <= '0;
    end else if (start && (winner == PORT0)) begin
      starve_cnt <= '0;
    end else if (req0 && !p0_grant && !starve) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`endif

  sdram_arb_select u_select (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
`ifndef SDRAM_ARB_ROUND_ROBIN_EN
    .starve     (starve),
`endif
    .winner     (winner)
  );

  // State register plus the owner, operation type and last winner latched at the decision.
  always_ff @(posedge sdram_clock or negedge sdram_reset_n) begin
    if (!sdram_reset_n) begin
      state      <= IDLE;
      owner      <= PORT0;
      op_write   <= 1'b0;
      last_grant <= PORT1;
    end else begin
      state <= state_next;
      if (start) begin
        owner      <= winner;
        op_write   <= (winner == PORT1) ? p1_write : p0_write;
        last_grant <= winner;
      end
    end
  end

  // Next-state logic for the request / flag-rise / flag-fall handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE: begin
        if (flag) begin
          state_next = XFER;
        end else if (!owner_req) begin
          state_next = ABORT;
        end
      end
      XFER:    if (!flag) state_next = DONE;
      DONE:    if (!owner_req) state_next = IDLE;
      ABORT:   if (ctl_idle) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grants, controller bus muxing and per-port strobes derived from state and owner.
  always_comb begin
    logic granted;
    logic driving;
    granted           = (state == ISSUE) || (state == XFER) || (state == DONE);
    driving           = (state == ISSUE) || (state == XFER);
    ctl_address       = '0;
    ctl_num           = '0;
    ctl_data_in       = '0;
    ctl_write_request = 1'b0;
    ctl_read_request  = 1'b0;
    if (driving) begin
      ctl_address = (owner == PORT1) ? p1_address : p0_address;
      ctl_num     = fix_num((owner == PORT1) ? p1_num : p0_num);
      ctl_data_in = (owner == PORT1) ? p1_wdata : p0_wdata;
    end
    if (state == ISSUE) begin
      ctl_write_request = op_write;
      ctl_read_request  = !op_write;
    end
    p0_grant  = granted && (owner == PORT0);
    p1_grant  = granted && (owner == PORT1);
    p0_wready = ctl_write_flag && p0_grant;
    p1_wready = ctl_write_flag && p1_grant;
    p0_done   = done_q && (owner == PORT0);
    p1_done   = done_q && (owner == PORT1);
    p0_rvalid = rvalid0_q;
    p1_rvalid = rvalid1_q;
    p0_rdata  = rdata0_q;
    p1_rdata  = rdata1_q;
  end

  // Done strobe on entry to DONE; read data and valid registered together on the flag cycle.
  always_ff @(posedge sdram_clock or negedge sdram_reset_n) begin
    if (!sdram_reset_n) begin
      done_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      done_q    <= (state == XFER) && !flag;
      rvalid0_q <= ctl_read_flag && p0_grant;
      rvalid1_q <= ctl_read_flag && p1_grant;
      if (ctl_read_flag && p0_grant) rdata0_q <= ctl_data_out;
      if (ctl_read_flag && p1_grant) rdata1_q <= ctl_data_out;
    end
  end

  // Beats seen in the current burst, saturating at the counter's maximum.
  always_ff @(posedge sdram_clock or negedge sdram_reset_n) begin
    if (!sdram_reset_n) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (driving_beat(state, flag) && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + NUM_W'(1);
    end
  end

  function automatic logic driving_beat(input arb_state_t st, input logic fl);
    return fl && ((st == ISSUE) || (st == XFER));
  endfunction

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [24:0] p0_address, p1_address, ctl_address;
  logic [9:0]  p0_num, p1_num, ctl_num;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ctl_data_in, ctl_data_out;
  logic p0_write, p0_read, p1_write, p1_read;
  logic p0_grant, p0_wready, p0_rvalid, p0_done;
  logic p1_grant, p1_wready, p1_rvalid, p1_done;
  logic ctl_write_request, ctl_read_request;
  logic ctl_write_flag, ctl_read_flag, ctl_idle, ctl_refresh_mode;

  int errors = 0;
  int checks = 0;
  int order[$];
  int first0;

  sdram_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .sdram_clock(clk), .sdram_reset_n(rst_n),
    .p0_address(p0_address), .p0_num(p0_num), .p0_wdata(p0_wdata),
    .p0_write(p0_write), .p0_read(p0_read), .p0_grant(p0_grant),
    .p0_wready(p0_wready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_done(p0_done),
    .p1_address(p1_address), .p1_num(p1_num), .p1_wdata(p1_wdata),
    .p1_write(p1_write), .p1_read(p1_read), .p1_grant(p1_grant),
    .p1_wready(p1_wready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_done(p1_done),
    .ctl_address(ctl_address), .ctl_num(ctl_num), .ctl_data_in(ctl_data_in),
    .ctl_write_request(ctl_write_request), .ctl_read_request(ctl_read_request),
    .ctl_write_flag(ctl_write_flag), .ctl_read_flag(ctl_read_flag),
    .ctl_data_out(ctl_data_out), .ctl_idle(ctl_idle), .ctl_refresh_mode(ctl_refresh_mode)
  );

  // in    = {p0_write, p0_read, p1_read, write_flag, read_flag, ctl_idle}
  // flags = {p0_grant, p1_grant, wr_req, rd_req, p0_wready, p0_rvalid, p1_rvalid, p0_done, p1_done}
  typedef struct {
    logic [5:0]  in;
    logic [15:0] dout;
    logic [8:0]  flags;
    logic [15:0] din;
    logic [24:0] addr;
    logic [9:0]  num;
  } vec_t;

  vec_t vt[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs_or();
    return {48'd0, p0_grant, p1_grant, p0_wready, p1_wready, p0_rvalid, p1_rvalid,
            p0_done, p1_done, ctl_write_request, ctl_read_request,
            |p0_rdata, |p1_rdata, |ctl_address, |ctl_num, |ctl_data_in, 1'b0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    p0_write = 0; p0_read = 0; p1_write = 0; p1_read = 0;
    ctl_write_flag = 0; ctl_read_flag = 0; ctl_idle = 1; ctl_refresh_mode = 0;
    ctl_data_out = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Simple controller (one-beat read after each request) plus requesters that
  // drop for one cycle after their done and re-request; records grant order.
  task automatic run_grants(input int n, input bit use0, input bit use1);
    int cyc;
    logic fl, g0p, g1p;
    cyc = 0; fl = 0; g0p = 0; g1p = 0; first0 = -1;
    order.delete();
    while (order.size() < n && cyc < 200) begin
      @(negedge clk);
      if (fl) fl = 0;
      else if (ctl_read_request || ctl_write_request) fl = 1;
      ctl_read_flag = fl;
      ctl_idle = 1;
      p0_read = p0_done ? 1'b0 : use0;
      p1_read = p1_done ? 1'b0 : use1;
      if (p0_grant && !g0p) begin order.push_back(0); if (first0 < 0) first0 = cyc; end
      if (p1_grant && !g1p) order.push_back(1);
      g0p = p0_grant; g1p = p1_grant;
      cyc++;
    end
    check("grant_budget", 64'(order.size()), 64'(n));
    p0_read = 0; p1_read = 0; ctl_read_flag = 0; ctl_idle = 1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int bad;
    logic [63:0] code;
    p0_address = 25'h000123; p1_address = 25'h000456;
    p0_wdata = 16'hA55A;     p1_wdata = 16'h0F0F;
    p0_num = 10'd1;          p1_num = 10'd0;

    vt[0]  = '{6'b100001, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[1]  = '{6'b100001, 16'h0,    9'b101000000, 16'hA55A, 25'h123, 10'd1};
    vt[2]  = '{6'b100100, 16'h0,    9'b101010000, 16'hA55A, 25'h123, 10'd1};
    vt[3]  = '{6'b100000, 16'h0,    9'b100000000, 16'hA55A, 25'h123, 10'd1};
    vt[4]  = '{6'b100001, 16'h0,    9'b100000010, 16'h0,    25'h0,   10'd0};
    vt[5]  = '{6'b000001, 16'h0,    9'b100000000, 16'h0,    25'h0,   10'd0};
    vt[6]  = '{6'b000001, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[7]  = '{6'b011001, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[8]  = '{6'b011001, 16'h0,    9'b010100000, 16'h0F0F, 25'h456, 10'd1};
    vt[9]  = '{6'b011010, 16'hBEEF, 9'b010100000, 16'h0F0F, 25'h456, 10'd1};
    vt[10] = '{6'b011000, 16'h0,    9'b010000100, 16'h0F0F, 25'h456, 10'd1};
    vt[11] = '{6'b011001, 16'h0,    9'b010000001, 16'h0,    25'h0,   10'd0};
    vt[12] = '{6'b010001, 16'h0,    9'b010000000, 16'h0,    25'h0,   10'd0};
    vt[13] = '{6'b010001, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[14] = '{6'b010001, 16'h0,    9'b100100000, 16'hA55A, 25'h123, 10'd1};
    vt[15] = '{6'b000000, 16'h0,    9'b100100000, 16'hA55A, 25'h123, 10'd1};
    vt[16] = '{6'b000000, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[17] = '{6'b000000, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[18] = '{6'b000001, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[19] = '{6'b010001, 16'h0,    9'b000000000, 16'h0,    25'h0,   10'd0};
    vt[20] = '{6'b010001, 16'h0,    9'b100100000, 16'hA55A, 25'h123, 10'd1};

    do_reset();
    rst_n = 1'b0;
    #2;
    check("reset_outputs", all_outputs_or(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write on port 0, dual read (port 1 first), then a port 0 abort.
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      {p0_write, p0_read, p1_read, ctl_write_flag, ctl_read_flag, ctl_idle} = vt[i].in;
      ctl_data_out = vt[i].dout;
      #2;
      check($sformatf("vec%0d", i),
            {4'd0, p0_grant, p1_grant, ctl_write_request, ctl_read_request, p0_wready,
             p0_rvalid, p1_rvalid, p0_done, p1_done, ctl_data_in, ctl_address, ctl_num},
            {4'd0, vt[i].flags, vt[i].din, vt[i].addr, vt[i].num});
    end
    check("p1_rdata_held", 64'(p1_rdata), 64'h BEEF);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    do_reset();
    run_grants(1, 1'b1, 1'b0);
    run_grants(4, 1'b1, 1'b1);
    code = 64'(order[0] * 1000 + order[1] * 100 + order[2] * 10 + order[3]);
    check("rr_order", code, 64'd1010);
`else
    do_reset();
    run_grants(3, 1'b1, 1'b1);
    code = 64'(order[0] * 100 + order[1] * 10 + order[2]);
    check("starve_order", code, 64'd110);
    check("starve_grant_cycle", 64'(first0), 64'd9);
`endif

    // Refresh holds off the decision; grant one cycle after it falls.
    do_reset();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ctl_refresh_mode = 1; ctl_idle = 1; p0_read = 1;
      #2;
      if (p0_grant) bad++;
    end
    @(negedge clk);
    ctl_refresh_mode = 0;
    #2;
    if (p0_grant) bad++;
    check("refresh_no_grant", 64'(bad), 64'd0);
    @(negedge clk);
    #2;
    check("refresh_grant_after", 64'(p0_grant), 64'd1);

    // Asynchronous reset in the middle of a 4-beat read.
    do_reset();
    p0_num = 10'd4;
    @(negedge clk);
    p0_read = 1; ctl_idle = 1;
    @(negedge clk);
    ctl_read_flag = 1; ctl_idle = 0; ctl_data_out = 16'h1234;
    @(negedge clk);
    ctl_data_out = 16'h5678;
    #2;
    check("xfer_rvalid", 64'(p0_rvalid), 64'd1);
    check("xfer_rdata", 64'(p0_rdata), 64'h1234);
    check("xfer_num", 64'(ctl_num), 64'd4);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs_or(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; p0_read = 0; ctl_read_flag = 0; ctl_idle = 1;
    #2;
    check("post_reset_outputs", all_outputs_or(), 64'd0);
    @(negedge clk);
    p0_read = 1;
    @(negedge clk);
    #2;
    check("post_reset_regrant", 64'(p0_grant), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
